// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: sequences lw/sw/R/beq/j/addi over 3-5 cycles,
// stalls on mem_ready_i, takes a vectored interrupt between instructions and
// counts retired instructions (wrapping) for the display path.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   opcode_i           instruction opcode field, valid from DECODE onward
//   mem_ready_i        memory completes the current access this cycle
//   interrupt_i        level interrupt request, sampled at instruction boundaries
//   pc_write_o .. alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o
//                      datapath controls (Moore decode of state, FETCH and
//                      MEM_WRITE also look at mem_ready_i)
//   state_o            current state code for debug
//   instr_retired_o, illegal_op_o, irq_ack_o   single-cycle pulses
//   retired_count_o    retired instructions modulo 2^CNT_W
module mips_mc_control #(
  parameter int unsigned OPW        = 6,
  parameter int unsigned CNT_W      = 16,
  parameter bit          IRQ_ENABLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [OPW-1:0]   opcode_i,
  input  logic             mem_ready_i,
  input  logic             interrupt_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             instr_retired_o,
  output logic             illegal_op_o,
  output logic             irq_ack_o,
  output logic [CNT_W-1:0] retired_count_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_IRQ       = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic             op_lw_q, op_lw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           boundary_c;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       retire_c, illegal_c, irq_ack_c;

  // Where an instruction goes when it finishes.
  assign boundary_c = (IRQ_ENABLE && interrupt_i) ? S_IRQ : S_FETCH;

  // State, held lw/sw flag and retired counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      op_lw_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_lw_q <= op_lw_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d         = state_q;
    op_lw_d         = op_lw_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    retire_c        = 1'b0;
    illegal_c       = 1'b0;
    irq_ack_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        // Full-width compare: any nonzero bit above bit 5 makes it illegal.
        case (opcode_i)
          OPW'(OP_LW): begin
            state_d = S_MEM_ADDR;
            op_lw_d = 1'b1;
          end
          OPW'(OP_SW): begin
            state_d = S_MEM_ADDR;
            op_lw_d = 1'b0;
          end
          OPW'(OP_RTYPE): state_d = S_EXECUTE;
          OPW'(OP_BEQ):   state_d = S_BRANCH;
          OPW'(OP_J):     state_d = S_JUMP;
          OPW'(OP_ADDI):  state_d = S_ADDI_EX;
          default: begin
            illegal_c = 1'b1;
            state_d   = boundary_c;
          end
        endcase
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (state_q == S_ADDI_EX) begin
          state_d = S_ADDI_WB;
        end else begin
          state_d = op_lw_q ? S_MEM_READ : S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire_c     = 1'b1;
        state_d      = boundary_c;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (mem_ready_i) begin
          retire_c = 1'b1;
          state_d  = boundary_c;
        end
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire_c    = 1'b1;
        state_d     = boundary_c;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = boundary_c;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        retire_c        = 1'b1;
        state_d         = boundary_c;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        retire_c    = 1'b1;
        state_d     = boundary_c;
      end
      S_IRQ: begin
        // Interrupt is not re-sampled here so IRQs are always separated by a FETCH.
        pc_write_c  = 1'b1;
        pc_source_c = 2'b11;
        irq_ack_c   = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

  // Reset forces every control to 0, including FETCH's otherwise-active ones.
  assign pc_write_o      = rst_ni & pc_write_c;
  assign pc_write_cond_o = rst_ni & pc_write_cond_c;
  assign i_or_d_o        = rst_ni & i_or_d_c;
  assign mem_read_o      = rst_ni & mem_read_c;
  assign mem_write_o     = rst_ni & mem_write_c;
  assign ir_write_o      = rst_ni & ir_write_c;
  assign mem_to_reg_o    = rst_ni & mem_to_reg_c;
  assign reg_dst_o       = rst_ni & reg_dst_c;
  assign reg_write_o     = rst_ni & reg_write_c;
  assign alu_src_a_o     = rst_ni & alu_src_a_c;
  assign alu_src_b_o     = {2{rst_ni}} & alu_src_b_c;
  assign alu_op_o        = {2{rst_ni}} & alu_op_c;
  assign pc_source_o     = {2{rst_ni}} & pc_source_c;
  assign instr_retired_o = rst_ni & retire_c;
  assign illegal_op_o    = rst_ni & illegal_c;
  assign irq_ack_o       = rst_ni & irq_ack_c;
  assign state_o         = state_q;
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: default instance plus an IRQ-disabled
// instance and a 4-bit-counter instance, all driven by the same stimulus.
module tb_mips_mc_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic mem_ready;
  logic interrupt;

  int checks = 0;
  int errors = 0;

  // Default instance outputs
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic instr_retired, illegal_op, irq_ack;
  logic [15:0] retired_count;
  logic [15:0] ctl;

  // IRQ_ENABLE=0 instance outputs
  logic n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
  logic [3:0] n_state;
  logic n_instr_retired, n_illegal_op, n_irq_ack;
  logic [15:0] n_retired_count;

  // CNT_W=4 instance outputs
  logic c_pc_write, c_pc_write_cond, c_i_or_d, c_mem_read, c_mem_write, c_ir_write;
  logic c_mem_to_reg, c_reg_dst, c_reg_write, c_alu_src_a;
  logic [1:0] c_alu_src_b, c_alu_op, c_pc_source;
  logic [3:0] c_state;
  logic c_instr_retired, c_illegal_op, c_irq_ack;
  logic [3:0] c_retired_count;

  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .interrupt_i(interrupt),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .state_o(state), .instr_retired_o(instr_retired),
    .illegal_op_o(illegal_op), .irq_ack_o(irq_ack), .retired_count_o(retired_count)
  );

  mips_mc_control #(.IRQ_ENABLE(1'b0)) dut_noirq (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .interrupt_i(interrupt),
    .pc_write_o(n_pc_write), .pc_write_cond_o(n_pc_write_cond), .i_or_d_o(n_i_or_d),
    .mem_read_o(n_mem_read), .mem_write_o(n_mem_write), .ir_write_o(n_ir_write),
    .mem_to_reg_o(n_mem_to_reg), .reg_dst_o(n_reg_dst), .reg_write_o(n_reg_write),
    .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b), .alu_op_o(n_alu_op),
    .pc_source_o(n_pc_source), .state_o(n_state), .instr_retired_o(n_instr_retired),
    .illegal_op_o(n_illegal_op), .irq_ack_o(n_irq_ack), .retired_count_o(n_retired_count)
  );

  mips_mc_control #(.CNT_W(4)) dut_c4 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .interrupt_i(interrupt),
    .pc_write_o(c_pc_write), .pc_write_cond_o(c_pc_write_cond), .i_or_d_o(c_i_or_d),
    .mem_read_o(c_mem_read), .mem_write_o(c_mem_write), .ir_write_o(c_ir_write),
    .mem_to_reg_o(c_mem_to_reg), .reg_dst_o(c_reg_dst), .reg_write_o(c_reg_write),
    .alu_src_a_o(c_alu_src_a), .alu_src_b_o(c_alu_src_b), .alu_op_o(c_alu_op),
    .pc_source_o(c_pc_source), .state_o(c_state), .instr_retired_o(c_instr_retired),
    .illegal_op_o(c_illegal_op), .irq_ack_o(c_irq_ack), .retired_count_o(c_retired_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release on a falling edge; ends in the first FETCH cycle.
  task automatic apply_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    interrupt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    opcode    = OP_LW;
    mem_ready = 1'b1;
    interrupt = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (ctl !== 16'h0000) begin errors++; $display("FAIL reset_ctl got %h want 0000", ctl); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({instr_retired, illegal_op, irq_ack} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {instr_retired, illegal_op, irq_ack}); end
    checks++; if (ctl !== 16'h0000) begin errors++; $display("FAIL reset_ctl_hold got %h want 0000", ctl); end
    checks++; if (retired_count !== 16'd0 || c_retired_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d/%0d want 0/0", retired_count, c_retired_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL release_state got %0d want 0", state); end
    checks++; if (ctl !== 16'h9410) begin errors++; $display("FAIL release_fetch_ctl got %h want 9410", ctl); end
  endtask

  task automatic test_lw();
    logic [3:0]  exp_st  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] exp_ctl [5] = '{16'h0030, 16'h0060, 16'h3000, 16'h0280, 16'h9410};
    logic        exp_ret [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    opcode = OP_LW;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      checks++; if (ctl !== exp_ctl[i]) begin errors++; $display("FAIL lw_ctl[%0d] got %h want %h", i, ctl, exp_ctl[i]); end
      checks++; if (instr_retired !== exp_ret[i]) begin errors++; $display("FAIL lw_retired[%0d] got %b want %b", i, instr_retired, exp_ret[i]); end
    end
    checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL lw_count got %0d want 1", retired_count); end
  endtask

  task automatic test_sw_stall();
    logic       rdy    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_st [6] = '{4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    int mw_cnt  = 0;
    int ret_cnt = 0;
    int pcw_bad = 0;
    apply_reset();
    opcode = OP_SW;
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_ready = rdy[i];
      #1;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      if (mem_write === 1'b1) mw_cnt++;
      if (instr_retired === 1'b1) ret_cnt++;
      if (pc_write === 1'b1) pcw_bad++;
    end
    mem_ready = 1'b1;
    tick();
    checks++; if (mw_cnt != 4) begin errors++; $display("FAIL sw_mem_write_cycles got %0d want 4", mw_cnt); end
    checks++; if (ret_cnt != 1) begin errors++; $display("FAIL sw_retire_pulses got %0d want 1", ret_cnt); end
    checks++; if (pcw_bad != 0) begin errors++; $display("FAIL sw_pc_write_outside_fetch got %0d want 0", pcw_bad); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_end_state got %0d want 0", state); end
    checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL sw_count got %0d want 1", retired_count); end
  endtask

  task automatic test_sequence();
    logic [5:0] ops     [4] = '{OP_R, OP_BEQ, OP_J, OP_ADDI};
    int         exp_cyc [4] = '{4, 3, 3, 4};
    logic [1:0] br_src  = 2'bxx;
    logic [1:0] j_src   = 2'bxx;
    int cyc;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      cyc = 0;
      do begin
        tick();
        cyc++;
        if (state === 4'd8) br_src = pc_source;
        if (state === 4'd9) j_src  = pc_source;
      end while (state !== 4'd0 && cyc < 20);
      checks++; if (cyc != exp_cyc[i]) begin errors++; $display("FAIL seq_cycles[%0d] got %0d want %0d", i, cyc, exp_cyc[i]); end
    end
    checks++; if (br_src !== 2'b01) begin errors++; $display("FAIL seq_branch_pc_source got %b want 01", br_src); end
    checks++; if (j_src !== 2'b10) begin errors++; $display("FAIL seq_jump_pc_source got %b want 10", j_src); end
    checks++; if (retired_count !== 16'd4) begin errors++; $display("FAIL seq_count got %0d want 4", retired_count); end
  endtask

  task automatic test_illegal();
    apply_reset();
    opcode = 6'b111111;
    tick();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill_decode_state got %0d want 1", state); end
    checks++; if (illegal_op !== 1'b1 || instr_retired !== 1'b0) begin errors++; $display("FAIL ill_pulse got ill=%b ret=%b want 1/0", illegal_op, instr_retired); end
    tick();
    checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin errors++; $display("FAIL ill_next got state=%0d ill=%b want 0/0", state, illegal_op); end
    checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL ill_count got %0d want 0", retired_count); end
  endtask

  task automatic test_irq();
    apply_reset();
    opcode = OP_R;
    tick();
    tick();
    tick();
    interrupt = 1'b1;
    #1;
    checks++; if (state !== 4'd7 || n_state !== 4'd7) begin errors++; $display("FAIL irq_rwb got %0d/%0d want 7/7", state, n_state); end
    tick();
    checks++; if (state !== 4'd12) begin errors++; $display("FAIL irq_state got %0d want 12", state); end
    checks++; if (ctl !== 16'h8003 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ctl got %h ack=%b want 8003 ack=1", ctl, irq_ack); end
    checks++; if (n_state !== 4'd0 || n_irq_ack !== 1'b0) begin errors++; $display("FAIL irq_disabled got state=%0d ack=%b want 0/0", n_state, n_irq_ack); end
    tick();
    checks++; if (state !== 4'd0 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_after got state=%0d ack=%b want 0/0", state, irq_ack); end
    checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL irq_count got %0d want 1", retired_count); end
    interrupt = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    opcode = OP_J;
    repeat (51) tick();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL wrap_state got %0d want 0", state); end
    checks++; if (c_retired_count !== 4'd1) begin errors++; $display("FAIL wrap_count4 got %0d want 1", c_retired_count); end
    checks++; if (retired_count !== 16'd17) begin errors++; $display("FAIL wrap_count16 got %0d want 17", retired_count); end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LW;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL mid_pre_state got %0d want 3", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || ctl !== 16'h0000) begin errors++; $display("FAIL mid_reset got state=%0d ctl=%h want 0/0000", state, ctl); end
    checks++; if (instr_retired !== 1'b0) begin errors++; $display("FAIL mid_retired got %b want 0", instr_retired); end
    checks++; if (retired_count !== 16'd0 || c_retired_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d/%0d want 0/0", retired_count, c_retired_count); end
    apply_reset();
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b1;
    interrupt = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_sequence();
    test_illegal();
    test_irq();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Parametrised multi-cycle control unit for the next-generation MIPS datapath, replacing the single-cycle `Unidade_de_controle` decode. A registered state machine sequences each instruction (lw, sw, R-type, beq, j, addi) over 3–5 cycles and stalls on a memory-ready handshake. It also takes a vectored interrupt between instructions and keeps a wrap-around retired-instruction counter for the 7-segment display path.

## Interface
- OPW, 6: opcode width; opcode values compared on the low 6 bits, upper bits must be 0.
- CNT_W, 16: width of retired_count.
- IRQ_ENABLE, 1: 0 = interrupt input ignored, IRQ state unreachable.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- opcode  in  OPW  instrucao[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes current access this cycle.
- interrupt  in  1  level request, sampled at instruction boundaries.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b, alu_op, pc_source  out  2 each  mux/ALU selects.
- state  out  4  current state, for debug.
- instr_retired, illegal_op, irq_ack  out  1 each  single-cycle pulses.
- retired_count  out  CNT_W  retired instructions, modulo 2^CNT_W.

## Operation
- States (encoding): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, IRQ=12. Codes 13–15 go to FETCH.
- Moore outputs decoded from state. Any control not listed for a state is 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEM_ADDR / ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - ADDI_WB: reg_write=1, reg_dst=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - IRQ: pc_write=1, pc_source=11, irq_ack=1.
- Transitions:
  - FETCH → DECODE when mem_ready=1; otherwise hold.
  - DECODE → by opcode: 100011/101011 → MEM_ADDR; 000000 → EXECUTE; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX.
  - Any other opcode in DECODE: illegal_op=1 for that cycle, next state is the boundary state (below), no retire.
  - MEM_ADDR → MEM_READ (lw) or MEM_WRITE (sw), using the opcode held from DECODE.
  - MEM_READ → MEM_WB on mem_ready; otherwise hold.
  - MEM_WRITE → boundary state on mem_ready; otherwise hold, with mem_write held high throughout.
  - EXECUTE → R_WB; ADDI_EX → ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP → boundary state.
  - IRQ → FETCH unconditionally.
- Boundary state: IRQ if IRQ_ENABLE and interrupt=1, else FETCH.
- instr_retired=1 in the final cycle of each instruction: MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, and MEM_WRITE when mem_ready=1. On each pulse retired_count increments; all-ones wraps to 0.

## Timing
- While reset=0 (asynchronous): state=FETCH, retired_count=0, all outputs forced to 0 including the pulses. The first cycle after release is FETCH.
- Reset asserted mid-instruction aborts it immediately: no retire, no count change.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3. IRQ adds 1 cycle.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- interrupt is sampled only in the final cycle of an instruction, or in the illegal-opcode DECODE cycle. It is never sampled during the IRQ state, so back-to-back IRQs always have a FETCH between them.
- retired_count updates on the clock edge that ends the retiring cycle.

## Test plan
- Reset release, mem_ready=1, opcode=100011 → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 in cycle 5. instr_retired=1 in cycle 5 only; retired_count=1.
- opcode=101011 with mem_ready low for 3 cycles in MEM_WRITE → mem_write high for 4 cycles, one retire pulse, pc_write never asserted outside FETCH.
- Sequence R-type, beq, j, addi → cycle counts 4,3,3,4. pc_source=01 in BRANCH and 10 in JUMP. retired_count=4.
- opcode=111111 → illegal_op pulse in DECODE, next state FETCH, retired_count unchanged.
- interrupt=1 during R_WB → next state IRQ (pc_write=1, pc_source=11, irq_ack=1), then FETCH even if interrupt is still high. With IRQ_ENABLE=0 the same stimulus goes straight to FETCH.
- CNT_W=4, retire 17 j instructions → retired_count=1. Assert reset in MEM_READ → outputs 0 immediately, count 0.
